// File: rtl/mips_lite_instr_encoder.sv
// MIPS-lite instruction encoder / program loader: packs instruction requests into 32-bit words,
// buffers them in a FIFO and streams them to instruction memory. Optional macro: MIPS_ENC_TERM_WORD_EN.
module mips_lite_instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 4,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              finish,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_shamt,
   input  logic [5:0]        req_funct,
   input  logic [15:0]       req_imm,
   input  logic [25:0]       req_target,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   input  logic              mem_ready,
   output logic              done,
   output logic [ADDR_W:0]   words,
   output logic              err_illegal,
   output logic              err_overflow
);

   localparam int                PW        = $clog2(DEPTH);
   localparam logic [PW:0]       FULL_CNT  = (PW+1)'(DEPTH);
   localparam logic [PW:0]       CNT_ONE   = (PW+1)'(1);
   localparam logic [PW-1:0]     PTR_ONE   = PW'(1);
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_TOP  = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   WORDS_ONE = (ADDR_W+1)'(1);
   localparam logic [31:0]       TERM_WORD = 32'hFFFF_FFFF;

   localparam logic [2:0] OP_RFMT    = 3'd0;
   localparam logic [2:0] OP_LW      = 3'd1;
   localparam logic [2:0] OP_SW      = 3'd2;
   localparam logic [2:0] OP_BEQ     = 3'd3;
   localparam logic [2:0] OP_NORI    = 3'd4;
   localparam logic [2:0] OP_JAL     = 3'd5;
   localparam logic [2:0] OP_JSP     = 3'd6;
   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FLUSH = 3'd2,
      S_TERM  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   function automatic logic [31:0] encode_word(
      input logic [2:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  shamt,
      input logic [5:0]  funct,
      input logic [15:0] imm,
      input logic [25:0] target
   );
      logic [31:0] w;
      case (op)
         OP_RFMT: w = {6'h00, rs, rt, rd, shamt, funct};
         OP_LW:   w = {6'h23, rs, rt, imm};
         OP_SW:   w = {6'h2B, rs, rt, imm};
         OP_BEQ:  w = {6'h04, rs, rt, imm};
         OP_NORI: w = {6'h0D, rs, rt, imm};
         OP_JAL:  w = {6'h03, target};
         OP_JSP:  w = {6'h12, target};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   state_t              state_r;
   state_t              state_s;
   logic [31:0]         mem_r [DEPTH];
   logic [PW-1:0]       rd_ptr_r;
   logic [PW-1:0]       wr_ptr_r;
   logic [PW:0]         count_r;
   logic [ADDR_W-1:0]   im_addr_r;
   logic [ADDR_W:0]     words_r;
   logic                err_illegal_r;
   logic                err_overflow_r;
   logic                exhausted_r;

   logic fifo_empty_s;
   logic fifo_full_s;
   logic drain_s;
   logic term_s;
   logic accept_s;
   logic illegal_s;
   logic push_s;
   logic pending_s;
   logic overflow_s;
   logic write_s;
   logic pop_s;

   assign fifo_empty_s = (count_r == '0);
   assign fifo_full_s  = (count_r == FULL_CNT);
   assign drain_s      = (state_r == S_LOAD) || (state_r == S_FLUSH);
   assign term_s       = (state_r == S_TERM);
   assign req_ready    = (state_r == S_LOAD) && !fifo_full_s;
   assign accept_s     = req_valid && req_ready;
   assign illegal_s    = accept_s && (req_op == OP_ILLEGAL);
   assign push_s       = accept_s && (req_op != OP_ILLEGAL);
   // A write is pending when a word waits in the FIFO or the terminator is due;
   // once the top address has been written, a pending write becomes an overflow instead.
   assign pending_s    = (drain_s && !fifo_empty_s) || term_s;
   assign overflow_s   = pending_s && exhausted_r;
   assign write_s      = im_we && mem_ready;
   assign pop_s        = write_s && drain_s;

   assign im_we        = pending_s && !exhausted_r;
   assign im_wdata     = term_s ? TERM_WORD : mem_r[rd_ptr_r];
   assign im_addr      = im_addr_r;
   assign words        = words_r;
   assign err_illegal  = err_illegal_r;
   assign err_overflow = err_overflow_r;
   assign done         = (state_r == S_DONE);

   // Session state register.
   always_ff @(posedge clk) begin
      if (!reset_n) state_r <= S_IDLE;
      else          state_r <= state_s;
   end

   // Session sequencing: load, drain on finish, optional terminator, one-cycle done.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) state_s = S_LOAD;
            else       state_s = S_IDLE;
         end
         S_LOAD: begin
            if (overflow_s)  state_s = S_DONE;
            else if (finish) state_s = S_FLUSH;
            else             state_s = S_LOAD;
         end
         S_FLUSH: begin
            if (overflow_s) begin
               state_s = S_DONE;
            end else if (fifo_empty_s) begin
`ifdef MIPS_ENC_TERM_WORD_EN
               state_s = S_TERM;
`else
               state_s = S_DONE;
`endif
            end else begin
               state_s = S_FLUSH;
            end
         end
         S_TERM: begin
            if (overflow_s || write_s) state_s = S_DONE;
            else                       state_s = S_TERM;
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= encode_word(req_op, req_rs, req_rt, req_rd,
                                        req_shamt, req_funct, req_imm, req_target);
      end
   end

   // FIFO pointers and occupancy; an overflow discards everything still queued.
   always_ff @(posedge clk) begin
      if (!reset_n || overflow_s) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Write address, word count and sticky status, all re-armed by start in IDLE.
   always_ff @(posedge clk) begin
      if (!reset_n || ((state_r == S_IDLE) && start)) begin
         im_addr_r      <= BASE;
         words_r        <= '0;
         err_illegal_r  <= 1'b0;
         err_overflow_r <= 1'b0;
         exhausted_r    <= 1'b0;
      end else begin
         if (write_s) begin
            im_addr_r <= im_addr_r + ADDR_ONE;
            words_r   <= words_r + WORDS_ONE;
            if (im_addr_r == ADDR_TOP) exhausted_r <= 1'b1;
         end
         if (illegal_s)  err_illegal_r  <= 1'b1;
         if (overflow_s) err_overflow_r <= 1'b1;
      end
   end

endmodule
